riscv_if_fetch: RTL and testbench

- Parametrised fetch stage with a registered PC and a valid/ready instruction-memory request/response interface.
- Holds an in-order prefetch queue of (instr, pc) pairs.
- Feeds ID through a valid/ready handshake.
- Supports redirect (branch/jump/trap) with flush of queued entries and squash of in-flight responses. Sits between imem and riscv_ID.

---
 rtl/riscv_if_fetch_pkg.sv | 21 ++
 rtl/riscv_adder.sv | 16 +
 rtl/riscv_if_fetch_fifo.sv | 89 ++++++++
 rtl/riscv_if_fetch.sv | 154 +++++++++++++++
 tb/tb_riscv_if_fetch.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_if_fetch_pkg.sv
// riscv_if_fetch_pkg
// Shared configuration for the fetch stage: default datapath width, default
// reset PC, the instruction size in bytes and a constant-foldable clog2 helper.
// No ports (package).
package riscv_if_fetch_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int unsigned INSTR_BYTES  = 4;

  // Ceiling log2; clog2(1) = 0. Used for pointer and counter widths.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/riscv_adder.sv
// riscv_adder
// Plain WIDTH-bit adder, wraps modulo 2^WIDTH. Used for every PC + 4.
// Ports:
//   i_a, i_b  in  WIDTH  operands
//   o_sum     out WIDTH  i_a + i_b (carry discarded)
module riscv_adder #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/riscv_if_fetch_fifo.sv
// riscv_if_fifo
// Synchronous FIFO holding the prefetched (instr, pc) pairs. Head data is read
// combinationally so an entry written in cycle N is visible in cycle N+1.
// Flush has priority over push and pop. DEPTH must be a power of 2, >= 2.
// Ports:
//   i_clk, i_rstn  in  1      clock, asynchronous active-low reset
//   i_push         in  1      write i_data at the tail
//   i_data         in  WIDTH  tail data
//   i_pop          in  1      drop the head entry (ignored when empty)
//   i_flush        in  1      empty the queue
//   o_data         out WIDTH  head entry
//   o_count        out CW     number of valid entries
module riscv_if_fifo
  import riscv_if_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);

  localparam int unsigned AW = clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign do_push = i_push && !i_flush;
  assign do_pop  = i_pop && !i_flush && (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (i_flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of 2.
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is left unreset so it can map onto distributed RAM.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_q] <= i_data;
  end

  assign o_data  = mem_q[rd_q];
  assign o_count = cnt_q;

`ifndef SYNTHESIS
  // The fetch credit scheme must never overfill the queue.
  always_ff @(posedge i_clk) begin
    if (i_rstn) begin
      assert (!(do_push && !do_pop && (cnt_q == DEPTH_C)))
        else $error("riscv_if_fifo: push into full queue");
    end
  end
`endif

endmodule

// File: rtl/riscv_if_fetch.sv
// riscv_if_fetch
// Instruction fetch stage. Issues PC-sequential requests to imem under a
// credit limit (queued + outstanding <= FIFO_DEPTH), tags in-order responses
// with their PC, queues them and hands them to ID over valid/ready. A redirect
// reloads the PC, flushes the queue and arranges for every response still in
// flight to be discarded.
// Optional build macro: RISCV_IF_PERF_EN adds performance counter outputs.
// Ports:
//   i_clk, i_rstn        in   clock, asynchronous active-low reset
//   o_imem_req_valid     out  request valid      i_imem_req_ready in  accepted
//   o_imem_addr          out  request address (the PC register)
//   i_imem_rsp_valid     in   response valid     i_imem_rsp_data  in  instr
//   i_redirect_valid     in   redirect           i_redirect_pc    in  target
//   o_IF_valid           out  head valid to ID   i_IF_ready       in  ID accept
//   o_IF_instr, o_IF_pc  out  head entry         o_IF_pc4         out head pc+4
//   o_perf_fetch_cnt / o_perf_stall_cnt / o_perf_flush_cnt (RISCV_IF_PERF_EN)
module riscv_if_fetch
  import riscv_if_fetch_pkg::*;
#(
  parameter int unsigned         XLEN       = XLEN_DEF,
  parameter logic [XLEN-1:0]     RESET_PC   = XLEN'(RESET_PC_DEF),
  parameter int unsigned         FIFO_DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  output logic            o_imem_req_valid,
  input  logic            i_imem_req_ready,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_rsp_valid,
  input  logic [XLEN-1:0] i_imem_rsp_data,
  input  logic            i_redirect_valid,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_IF_valid,
  input  logic            i_IF_ready,
  output logic [XLEN-1:0] o_IF_instr,
  output logic [XLEN-1:0] o_IF_pc,
  output logic [XLEN-1:0] o_IF_pc4
`ifdef RISCV_IF_PERF_EN
  , output logic [XLEN-1:0] o_perf_fetch_cnt
  , output logic [XLEN-1:0] o_perf_stall_cnt
  , output logic [XLEN-1:0] o_perf_flush_cnt
`endif
);

  localparam int unsigned     CW   = clog2(FIFO_DEPTH + 1);
  localparam logic [XLEN-1:0] STEP = XLEN'(INSTR_BYTES);

  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]     out_q, out_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     fifo_count;
  logic [2*XLEN-1:0] fifo_head;
  logic [CW:0]       inflight;
  logic [XLEN-1:0]   pc_plus4, rsp_pc_plus4, target;
  logic              req_fire, rsp_drop, push, pop;

  // Extra bit so the sum of two counters cannot overflow before comparing.
  assign inflight = {1'b0, fifo_count} + {1'b0, out_q};

  assign o_imem_req_valid = i_rstn && !i_redirect_valid &&
                            (inflight < (CW + 1)'(FIFO_DEPTH));
  assign o_imem_addr      = pc_q;
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  // A response arriving while stale responses are pending is one of them.
  assign rsp_drop = i_imem_rsp_valid && (drop_q != '0);
  assign push     = i_imem_rsp_valid && (drop_q == '0) && !i_redirect_valid;
  assign pop      = o_IF_valid && i_IF_ready;
  assign target   = i_redirect_pc & ~XLEN'(3);

  riscv_adder #(.WIDTH(XLEN)) u_req_add (
    .i_a(pc_q), .i_b(STEP), .o_sum(pc_plus4)
  );
  riscv_adder #(.WIDTH(XLEN)) u_rsp_add (
    .i_a(rsp_pc_q), .i_b(STEP), .o_sum(rsp_pc_plus4)
  );

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    drop_d   = drop_q;
    out_d    = out_q + CW'(req_fire) - CW'(i_imem_rsp_valid);
    if (i_redirect_valid) begin
      pc_d     = target;
      rsp_pc_d = target;
      // Everything still outstanding after this cycle is stale.
      drop_d   = out_q - CW'(i_imem_rsp_valid);
    end else begin
      if (req_fire) pc_d     = pc_plus4;
      if (push)     rsp_pc_d = rsp_pc_plus4;
      if (rsp_drop) drop_d   = drop_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
    end
  end

  riscv_if_fifo #(
    .WIDTH(2 * XLEN),
    .DEPTH(FIFO_DEPTH),
    .CW   (CW)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_push (push),
    .i_data ({i_imem_rsp_data, rsp_pc_q}),
    .i_pop  (pop),
    .i_flush(i_redirect_valid),
    .o_data (fifo_head),
    .o_count(fifo_count)
  );

  // Head fields are forced to zero while empty so ID never sees stale RAM.
  assign o_IF_valid = (fifo_count != '0);
  assign o_IF_instr = o_IF_valid ? fifo_head[2*XLEN-1:XLEN] : '0;
  assign o_IF_pc    = o_IF_valid ? fifo_head[XLEN-1:0]      : '0;

  riscv_adder #(.WIDTH(XLEN)) u_head_add (
    .i_a(o_IF_pc), .i_b(STEP), .o_sum(o_IF_pc4)
  );

`ifdef RISCV_IF_PERF_EN
  logic [XLEN-1:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (pop)                       fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
      if (!o_IF_valid && i_IF_ready) stall_cnt_q <= stall_cnt_q + XLEN'(1);
      if (i_redirect_valid)          flush_cnt_q <= flush_cnt_q + XLEN'(1);
    end
  end

  assign o_perf_fetch_cnt = fetch_cnt_q;
  assign o_perf_stall_cnt = stall_cnt_q;
  assign o_perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_if_fetch.sv
// tb_riscv_if_fetch
// Drives riscv_if_fetch with a behavioural in-order imem of configurable
// latency and checks the instruction stream seen by ID against the sequential
// PC stream implied by reset and redirects.
module tb_riscv_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready;
  logic [31:0] imem_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [31:0] if_instr, if_pc, if_pc4;
`ifdef RISCV_IF_PERF_EN
  logic [31:0] perf_fetch, perf_stall, perf_flush;
`endif

  always #5 clk = ~clk;

  riscv_if_fetch #(
    .XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rstn(rstn),
    .o_imem_req_valid(req_valid), .i_imem_req_ready(req_ready),
    .o_imem_addr(imem_addr),
    .i_imem_rsp_valid(rsp_valid), .i_imem_rsp_data(rsp_data),
    .i_redirect_valid(redirect), .i_redirect_pc(redirect_pc),
    .o_IF_valid(if_valid), .i_IF_ready(if_ready),
    .o_IF_instr(if_instr), .o_IF_pc(if_pc), .o_IF_pc4(if_pc4)
`ifdef RISCV_IF_PERF_EN
    , .o_perf_fetch_cnt(perf_fetch)
    , .o_perf_stall_cnt(perf_stall)
    , .o_perf_flush_cnt(perf_flush)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        imemq[$];
  int          cyc, last_due, lat_min, lat_max;
  int          errors, checks;
  int          fires, pops, stalls, flushes;
  logic [31:0] exp_pc, exp_req;
  logic        prev_redirect, prev_hold;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic perf_check();
`ifdef RISCV_IF_PERF_EN
    chk("perf_fetch", perf_fetch, fires >= 0 ? pops : 0);
    chk("perf_stall", perf_stall, stalls);
    chk("perf_flush", perf_flush, flushes);
`endif
  endtask

  // Called at posedge+1; returns at posedge+1 with the DUT held reset-free.
  task automatic do_reset();
    perf_check();
    rstn = 1'b0; redirect = 1'b0; rsp_valid = 1'b0;
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    imemq.delete();
    exp_pc = RST_PC; exp_req = RST_PC;
    prev_redirect = 1'b0; prev_hold = 1'b0;
    pops = 0; stalls = 0; flushes = 0; fires = 0;
    last_due = cyc;
`ifdef RISCV_IF_PERF_EN
    chk("rst_perf_fetch", perf_fetch, 0);
    chk("rst_perf_stall", perf_stall, 0);
    chk("rst_perf_flush", perf_flush, 0);
`endif
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
  endtask

  // One clock cycle: drive the imem response, check at negedge, update model.
  task automatic cycle();
    logic fire, pop, rsp;
    int   lat, due;
    if (imemq.size() != 0 && imemq[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = instr_of(imemq[0].addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = $urandom;
    end
    @(negedge clk);
    fire = req_valid && req_ready;
    pop  = if_valid && if_ready;
    rsp  = rsp_valid;
    chk("imem_addr", imem_addr, exp_req);
    if (redirect)      chk("req_blocked_on_redirect", req_valid, 0);
    if (prev_redirect) chk("empty_after_redirect", if_valid, 0);
    if (prev_hold && !redirect) chk("req_held", req_valid, 1);
    if (if_valid) begin
      chk("if_pc", if_pc, exp_pc);
      chk("if_instr", if_instr, instr_of(exp_pc));
      chk("if_pc4", if_pc4, exp_pc + 32'd4);
    end
    if (!if_valid && if_ready) stalls++;
    if (redirect) flushes++;
    @(posedge clk); #1;
    if (fire) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      imemq.push_back('{addr: exp_req, due: due});
      fires++;
    end
    if (rsp) void'(imemq.pop_front());
    if (pop) begin
      exp_pc = exp_pc + 32'd4;
      pops++;
    end
    if (redirect) begin
      exp_pc  = redirect_pc & ~32'd3;
      exp_req = redirect_pc & ~32'd3;
    end else if (fire) begin
      exp_req = exp_req + 32'd4;
    end
    prev_redirect = redirect;
    prev_hold     = req_valid && !req_ready;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0;
    errors = 0; checks = 0; cyc = 0;
    fires = 0; pops = 0; stalls = 0; flushes = 0;
    req_ready = 1'b1; if_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
    rsp_valid = 1'b0; rsp_data = '0; rstn = 1'b1;
    lat_min = 1; lat_max = 1;
    @(posedge clk); #1;

    // Streaming from reset with 1-cycle imem: one instruction per cycle.
    do_reset();
    run(10);
    p0 = pops;
    run(10);
    chk("zero_bubble_pops", pops - p0, 10);

    // ID stalled after a mid-run reset: exactly FIFO_DEPTH requests issued.
    do_reset();
    if_ready = 1'b0;
    run(10);
    chk("stall_fires", fires, 4);
    chk("stall_req_valid", req_valid, 0);
    chk("stall_if_valid", if_valid, 1);
    if_ready = 1'b1;
    p0 = pops;
    run(12);
    chk("drain_progress", (pops - p0) >= 8, 1);

    // imem ready toggling: address must hold while not accepted.
    for (int i = 0; i < 12; i++) begin
      req_ready = i[0];
      cycle();
    end
    req_ready = 1'b1;

    // 3-cycle imem, two requests in flight, redirect to a misaligned target.
    do_reset();
    lat_min = 3; lat_max = 3;
    cycle(); cycle();
    req_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_2002;
    cycle();
    redirect = 1'b0; req_ready = 1'b1;
    p0 = pops;
    run(20);
    chk("redirect_progress", (pops - p0) > 0, 1);

    // Redirect coinciding with a response and an ID pop; target wraps.
    lat_min = 1; lat_max = 1;
    run(8);
    chk("pre_redirect_head", if_valid, 1);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFA;
    cycle();
    redirect = 1'b0;
    p0 = pops;
    run(10);
    chk("wrap_progress", (pops - p0) >= 5, 1);

    // Randomized traffic with random latency, backpressure and redirects.
    do_reset();
    lat_min = 1; lat_max = 4;
    f0 = 0;
    for (int i = 0; i < 400; i++) begin
      req_ready   = ($urandom_range(3, 0) != 0);
      if_ready    = ($urandom_range(2, 0) != 0);
      redirect    = ($urandom_range(19, 0) == 0);
      redirect_pc = $urandom;
      if (redirect) f0++;
      cycle();
    end
    redirect = 1'b0; req_ready = 1'b1; if_ready = 1'b1;
    run(20);
    chk("random_flush_count", flushes, f0);

    perf_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
